servo_pwm_gen: RTL and testbench

- Consumer end of the position pipeline register: reads the registered servo position and generates the servo PWM frame.
- Issues a one-cycle pos_take strobe per frame. That strobe drives the upstream register's enable, so the position stream advances exactly once per frame.
- Sits between the position pipeline register and the servo output pin.

---
 rtl/servo_pwm_gen_pkg.sv | 30 +++
 rtl/servo_slew_limiter.sv | 28 ++
 rtl/servo_pwm_gen.sv | 126 ++++++++++++
 tb/tb_servo_pwm_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_gen_pkg.sv
// Shared types, default 50 MHz / 20 ms timing constants and the pulse-width helper
// for servo_pwm_gen (optional slew limiting under SERVO_PWM_SLEW_EN).
package servo_pwm_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } servo_state_t;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_PERIOD_TICKS = CLK_HZ / 50;    // 20 ms frame
  localparam int unsigned DEF_MIN_TICKS    = CLK_HZ / 1000;  // 1 ms pulse at position 0
  localparam int unsigned DEF_STEP_TICKS   = 196;
  localparam int unsigned DEF_MAX_TICKS    = 100_000;
  localparam int unsigned DEF_SLEW_MAX     = 4;

  // Full-width pulse width for a position, clamped to max_ticks.
  function automatic longint unsigned pulse_width(
    input longint unsigned shadow,
    input longint unsigned min_ticks,
    input longint unsigned step_ticks,
    input longint unsigned max_ticks
  );
    longint unsigned raw;
    raw = min_ticks + shadow * step_ticks;
    return (raw > max_ticks) ? max_ticks : raw;
  endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// Next shadow position: steps toward target by at most SLEW_MAX, landing exactly on it.
// Only built when SERVO_PWM_SLEW_EN is defined.
`ifdef SERVO_PWM_SLEW_EN
module servo_slew_limiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned SLEW_MAX = 4
) (
  input  logic [N-1:0] shadow,
  input  logic [N-1:0] target,
  output logic [N-1:0] next_shadow
);

  localparam int LIMIT = int'(SLEW_MAX);

  int diff;

  always_comb begin
    diff        = int'(target) - int'(shadow);
    next_shadow = target;
    if (diff > LIMIT) begin
      next_shadow = shadow + N'(SLEW_MAX);
    end else if (diff < -LIMIT) begin
      next_shadow = shadow - N'(SLEW_MAX);
    end
  end

endmodule
`endif

// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator; pulses pos_take once per frame to advance the upstream
// position register. Define SERVO_PWM_SLEW_EN to rate-limit the latched position.
module servo_pwm_gen
  import servo_pwm_gen_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int unsigned MIN_TICKS    = DEF_MIN_TICKS,
  parameter int unsigned STEP_TICKS   = DEF_STEP_TICKS,
  parameter int unsigned MAX_TICKS    = DEF_MAX_TICKS,
  parameter int unsigned SLEW_MAX     = DEF_SLEW_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [N-1:0] pos_in,
  output logic         pos_take,
  output logic         pwm_out,
  output logic         busy
);

  localparam int unsigned   CW        = $clog2(PERIOD_TICKS);
  localparam logic [CW-1:0] LAST_TICK = CW'(PERIOD_TICKS - 1);

  if (!(PERIOD_TICKS > MAX_TICKS && MAX_TICKS >= MIN_TICKS)) begin : g_bad_timing
    $fatal(1, "servo_pwm_gen: need PERIOD_TICKS > MAX_TICKS >= MIN_TICKS");
  end
  if (SLEW_MAX < 1) begin : g_bad_slew
    $fatal(1, "servo_pwm_gen: SLEW_MAX must be at least 1");
  end

  servo_state_t  state_reg, state_next;
  logic [CW-1:0] counter_reg, counter_next;
  logic [N-1:0]  shadow_reg, shadow_next;
  logic          take_reg, take_next;
  logic          pwm_reg, pwm_next;
  logic          busy_reg, busy_next;
  logic [N-1:0]  latch_pos;
  logic [CW-1:0] width;
  logic          high_done;

`ifdef SERVO_PWM_SLEW_EN
  servo_slew_limiter #(
    .N        (N),
    .SLEW_MAX (SLEW_MAX)
  ) u_slew (
    .shadow      (shadow_reg),
    .target      (pos_in),
    .next_shadow (latch_pos)
  );
`else
  assign latch_pos = pos_in;
`endif

  // Clamped width never exceeds MAX_TICKS < PERIOD_TICKS, so it fits the counter.
  assign width = CW'(pulse_width(64'(shadow_reg), 64'(MIN_TICKS),
                                 64'(STEP_TICKS), 64'(MAX_TICKS)));
  // Last high cycle; written as >= so a zero width still yields a bounded pulse.
  assign high_done = ({1'b0, counter_reg} + (CW + 1)'(1)) >= {1'b0, width};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      shadow_reg  <= '0;
      take_reg    <= 1'b0;
      pwm_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      shadow_reg  <= shadow_next;
      take_reg    <= take_next;
      pwm_reg     <= pwm_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    shadow_next  = shadow_reg;
    take_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next   = HIGH;
          counter_next = '0;
          shadow_next  = latch_pos;
          take_next    = 1'b1;
        end
      end
      HIGH: begin
        counter_next = counter_reg + CW'(1);
        if (high_done) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (counter_reg == LAST_TICK) begin
          counter_next = '0;
          if (run) begin
            state_next  = HIGH;
            shadow_next = latch_pos;
            take_next   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          counter_next = counter_reg + CW'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
    pwm_next  = (state_next == HIGH);
    busy_next = (state_next != IDLE);
  end

  assign pos_take = take_reg;
  assign pwm_out  = pwm_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: stimulus queues expected frames, a monitor
// checks pulse width, frame spacing and pos_take alignment.
module tb_servo_pwm_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] pos_in;
  logic       pos_take;
  logic       pwm_out;
  logic       busy;

  typedef struct {
    int width;
    int gap;   // expected cycles since previous pos_take; 0 = first frame, not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  servo_pwm_gen #(
    .N            (4),
    .PERIOD_TICKS (100),
    .MIN_TICKS    (10),
    .STEP_TICKS   (2),
    .MAX_TICKS    (36),
    .SLEW_MAX     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .pos_in   (pos_in),
    .pos_take (pos_take),
    .pwm_out  (pwm_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input int width, input int gap);
    exp_t e;
    e.width = width;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_take(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!pos_take && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!pos_take) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: no pos_take within 300 cycles", tag);
    end
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pwm_out || pos_take || busy) bad++;
    end
    check(name, bad, 0);
  endtask

  // Monitor: pops one expectation per pos_take, checks the pulse at its falling edge.
  initial begin : monitor
    logic prev_pwm;
    logic cur_valid;
    int   cur_width;
    int   high_cnt;
    int   last_take;
    exp_t e;
    prev_pwm  = 1'b0;
    cur_valid = 1'b0;
    cur_width = 0;
    high_cnt  = 0;
    last_take = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_pwm  = 1'b0;
        cur_valid = 1'b0;
        high_cnt  = 0;
      end else begin
        if (pos_take || (pwm_out && !prev_pwm)) begin
          check("take_on_rise{take,prev,pwm,busy}", {pos_take, prev_pwm, pwm_out, busy}, 4'b1011);
        end
        if (pos_take) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_take: pos_take at cycle %0d, no frame expected", cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.gap != 0) check("take_spacing", cyc - last_take, e.gap);
            cur_width = e.width;
            cur_valid = 1'b1;
          end
          last_take = cyc;
          high_cnt  = 0;
        end
        if (pwm_out) high_cnt++;
        if (prev_pwm && !pwm_out) begin
          if (cur_valid) begin
            check("pulse_width", high_cnt, cur_width);
          end else begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_pulse: width %0d, required none", high_cnt);
          end
          cur_valid = 1'b0;
          high_cnt  = 0;
        end
        prev_pwm = pwm_out;
      end
    end
  end

  initial begin : stimulus
    reset  = 1'b1;
    run    = 1'b0;
    pos_in = 4'd0;

    // Reset held, then released with run low.
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_take", int'(pos_take), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    quiet_window("idle_quiet_bad_cycles", 200);

`ifdef SERVO_PWM_SLEW_EN
    // Slew-limited approach 0 -> 13: 10, 18, 26, 34, 36 (clamped).
    push(10, 0);
    run = 1'b1;
    wait_take("slew_f1");
    pos_in = 4'd13;
    push(18, 100);
    push(26, 100);
    push(34, 100);
    push(36, 100);
    for (int i = 0; i < 4; i++) wait_take("slew_fn");
    run = 1'b0;
    repeat (110) @(negedge clk);
    check("slew_end_busy", int'(busy), 0);
`else
    // Position 0: 10 high / 90 low, frames back to back.
    push(10, 0);
    push(10, 100);
    run = 1'b1;
    wait_take("pos0_f1");
    wait_take("pos0_f2");
    // Position 15: 40 clamps to 36.
    pos_in = 4'd15;
    push(36, 100);
    push(36, 100);
    wait_take("pos15_f1");
    wait_take("pos15_f2");
    // Position 3, then 7 written at cycle 5 of that frame: 16 then 24.
    pos_in = 4'd3;
    push(16, 100);
    push(24, 100);
    wait_take("pos3_f1");
    repeat (5) @(negedge clk);
    pos_in = 4'd7;
    wait_take("pos7_f1");
    // Position 5, run dropped at cycle 4 of the pulse: 20 high, 80 low, then idle.
    pos_in = 4'd5;
    push(20, 100);
    wait_take("pos5_f1");
    repeat (4) @(negedge clk);
    run = 1'b0;
    repeat (95) @(negedge clk);
    check("stop_busy_cycle99", int'(busy), 1);
    @(negedge clk);
    check("stop_busy_cycle100", int'(busy), 0);
    quiet_window("stop_quiet_bad_cycles", 300);
    check("stop_queue_empty", exp_q.size(), 0);
`endif

    // Asynchronous reset in the middle of a pulse, then a clean restart.
    pos_in = 4'd0;
    push(10, 0);
    run = 1'b1;
    wait_take("abort_f1");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset{pwm,take,busy}", {pwm_out, pos_take, busy}, 3'b000);
    repeat (3) @(negedge clk);
    pos_in = 4'd2;
    push(14, 0);
    push(14, 100);
    reset = 1'b0;
    wait_take("restart_f1");
    wait_take("restart_f2");
    run = 1'b0;
    repeat (250) @(negedge clk);
    check("final_busy", int'(busy), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
